// File: rtl/binarysearch_pkg.sv
// Shared types and defaults for the binary-search scheduler: FSM states,
// datapath control bundle and the state-to-control decode.
package binarysearch_pkg;

    localparam int unsigned VAL_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GETMEM,
        S_COMPUTE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic set_L;
        logic set_R;
        logic set_M;
        logic load_A;
        logic done;
    } dp_ctrl_t;

    // Datapath controls that are active while the FSM sits in state s
    function automatic dp_ctrl_t ctrl_for(state_e s);
        dp_ctrl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c.set_L  = 1'b1;
                c.set_R  = 1'b1;
                c.load_A = 1'b1;
            end
            S_GETMEM: c.set_M = 1'b1;
            S_COMPUTE: begin
                c.set_M = 1'b1;
                c.set_L = 1'b1;
                c.set_R = 1'b1;
            end
            S_DONE:  c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/binarysearch_scheduler_if.sv
// Requester and datapath signal bundle for the binary-search scheduler.
interface binarysearch_scheduler_if
    import binarysearch_pkg::*;
#(
    parameter int unsigned VAL_WIDTH  = VAL_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic [1:0]            req;
    logic [VAL_WIDTH-1:0]  A0;
    logic [VAL_WIDTH-1:0]  A1;
    logic [1:0]            grant;
    logic [1:0]            rsp_valid;
    logic                  rsp_found;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    logic [VAL_WIDTH-1:0]  dp_A;
    logic                  set_L;
    logic                  set_R;
    logic                  set_M;
    logic                  load_A;
    logic                  done;
    logic                  F;
    logic                  NF;
    logic [ADDR_WIDTH-1:0] F_addr;

    modport slave (
        input  req, A0, A1, F, NF, F_addr,
        output grant, rsp_valid, rsp_found, rsp_err, rsp_addr,
        output dp_A, set_L, set_R, set_M, load_A, done
    );

    modport master (
        output req, A0, A1, F, NF, F_addr,
        input  grant, rsp_valid, rsp_found, rsp_err, rsp_addr,
        input  dp_A, set_L, set_R, set_M, load_A, done
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: pointer-preferred grant, pointer moves to the
// requester that lost (or was idle) whenever a grant is accepted.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr;
    logic other;

    assign other = ~ptr;

    always_comb begin
        grant_c = 2'b00;
        if (req[ptr]) begin
            grant_c[ptr] = 1'b1;
        end else if (req[other]) begin
            grant_c[other] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (accept && (grant_c != 2'b00)) begin
            ptr <= ~grant_c[1];
        end
    end

endmodule

// File: rtl/binarysearch_scheduler.sv
// Shares one binary-search datapath between two requesters: arbitrates,
// sequences the datapath through load/getmem/compute and returns the result.
module binarysearch_scheduler
    import binarysearch_pkg::*;
#(
    parameter int unsigned VAL_WIDTH  = VAL_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned MAX_ITER   = ADDR_WIDTH + 2
) (
    input  logic                     clock,
    input  logic                     reset,
    binarysearch_scheduler_if.slave  bus
);

    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

    state_e            state;
    state_e            next_state;
    logic [ITER_W-1:0] iter;
    logic [1:0]        arb_grant_c;
    logic              arb_accept_c;
    logic              search_end_c;
    dp_ctrl_t          ctrl_next_c;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (bus.req),
        .accept  (arb_accept_c),
        .grant_c (arb_grant_c)
    );

    // Next-state logic; controls are decoded from next_state so the
    // registered controls line up with the state they belong to.
    always_comb begin
        next_state   = state;
        arb_accept_c = 1'b0;
        search_end_c = bus.F | bus.NF | (iter == ITER_W'(MAX_ITER));
        case (state)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    arb_accept_c = 1'b1;
                    next_state   = S_LOAD;
                end
            end
            S_LOAD:    next_state = S_GETMEM;
            S_GETMEM:  next_state = search_end_c ? S_DONE : S_COMPUTE;
            S_COMPUTE: next_state = S_GETMEM;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        ctrl_next_c = ctrl_for(next_state);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            iter          <= '0;
            bus.grant     <= 2'b00;
            bus.rsp_valid <= 2'b00;
            bus.rsp_found <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_addr  <= '0;
            bus.dp_A      <= '0;
            bus.set_L     <= 1'b0;
            bus.set_R     <= 1'b0;
            bus.set_M     <= 1'b0;
            bus.load_A    <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= next_state;
            bus.set_L     <= ctrl_next_c.set_L;
            bus.set_R     <= ctrl_next_c.set_R;
            bus.set_M     <= ctrl_next_c.set_M;
            bus.load_A    <= ctrl_next_c.load_A;
            bus.done      <= ctrl_next_c.done;
            bus.rsp_valid <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (arb_accept_c) begin
                        bus.grant <= arb_grant_c;
                        bus.dp_A  <= arb_grant_c[1] ? bus.A1 : bus.A0;
                    end
                end
                S_LOAD: iter <= '0;
                // Result is captured here and presented for the single DONE cycle
                S_GETMEM: begin
                    if (search_end_c) begin
                        bus.rsp_valid <= bus.grant;
                        if (bus.F) begin
                            bus.rsp_found <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_addr  <= bus.F_addr;
                        end else if (bus.NF) begin
                            bus.rsp_found <= 1'b0;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_addr  <= '0;
                        end else begin
                            bus.rsp_found <= 1'b0;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_addr  <= '0;
                        end
                    end
                end
                S_COMPUTE: iter <= iter + ITER_W'(1);
                S_DONE:    bus.grant <= 2'b00;
                default:   iter <= iter;
            endcase
        end
    end

endmodule

// File: doc/binarysearch_scheduler.md
BINARYSEARCH_SCHEDULER -- requirements
Module: binarysearch_scheduler

Interface
REQ-001 The block SHALL have parameter VAL_WIDTH, default 8, search-value width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, datapath address width.
REQ-003 The block SHALL have parameter MAX_ITER, default ADDR_WIDTH+2, compute-cycle limit per search.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with ports: clock  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port req  in  2  per-requester level request, held until that requester's rsp_valid.
REQ-006 The block SHALL have ports A0, A1  in  VAL_WIDTH  search values for requesters 0 and 1.
REQ-007 The block SHALL have port grant  out  2  one-hot owner of the current search, 0 when idle.
REQ-008 The block SHALL have port rsp_valid  out  2  one-cycle result pulse to the owner.
REQ-009 The block SHALL have ports rsp_found, rsp_err  out  1 each; rsp_addr  out  ADDR_WIDTH; all valid with rsp_valid.
REQ-010 The block SHALL have port dp_A  out  VAL_WIDTH  search value to the datapath A input.
REQ-011 The block SHALL have ports set_L, set_R, set_M, load_A, done  out  1 each  datapath controls.
REQ-012 The block SHALL have ports F, NF  in  1 each; F_addr  in  ADDR_WIDTH  datapath status and found address.

Function
REQ-013 The FSM SHALL have the states S_IDLE, S_LOAD, S_GETMEM, S_COMPUTE and S_DONE.
REQ-014 In S_IDLE with req!=0, arbitration SHALL be round-robin: grant the requester at pointer ptr if it requests, else the other one.
  - ptr SHALL move to the non-granted requester.
  - dp_A SHALL register the granted A.
  - The FSM SHALL go to S_LOAD.
REQ-015 S_LOAD SHALL drive set_L=set_R=load_A=1 and set_M=0, then go to S_GETMEM.
REQ-016 S_GETMEM SHALL drive set_M=1 and set_L=set_R=0.
  - If F=1, it SHALL latch found=1 and addr=F_addr, then go to S_DONE.
  - Else if NF=1, it SHALL latch found=0 and addr=0, then go to S_DONE.
  - Else if iter==MAX_ITER, it SHALL latch err=1, then go to S_DONE.
  - Else it SHALL go to S_COMPUTE.
REQ-017 S_COMPUTE SHALL drive set_M=set_L=set_R=1, increment iter (width clog2(MAX_ITER+1), cleared in S_LOAD), then go to S_GETMEM.
REQ-018 S_DONE SHALL drive done=1 and all other controls 0, and pulse rsp_valid[owner] with the latched rsp_found, rsp_err and rsp_addr, then go to S_IDLE.
  - grant SHALL clear on the next cycle.
REQ-019 In S_IDLE and S_DONE all datapath controls other than done SHALL be 0.
REQ-020 The block SHALL hold grant constant from S_LOAD through S_DONE.
REQ-021 Requests arriving or dropping during a search SHALL NOT alter it; a dropped requester SHALL still receive its rsp_valid pulse.
REQ-022 When req=2'b11 in S_IDLE, the block SHALL grant per ptr, with no starvation: the other requester SHALL be served next.
REQ-023 Latency from grant to rsp_valid SHALL be 3+2k cycles, where k is the number of compute cycles (k<=MAX_ITER).
REQ-024 F and NF both 1 SHALL be treated as found (F has priority).

Reset
REQ-025 On reset, the block SHALL enter S_IDLE and force all of the following to 0: grant, rsp_valid, rsp_found, rsp_err, rsp_addr, dp_A, set_L, set_R, set_M, load_A, done, iter and ptr.
REQ-026 Reset mid-search SHALL abort the search without any rsp_valid pulse; the requester SHALL re-request.

Structure
REQ-027 A package binarysearch_pkg SHALL hold the state enum typedef and the default VAL_WIDTH and ADDR_WIDTH constants.
REQ-028 The block SHALL contain one sub-module, rr_arbiter2, for two-way round-robin pointer and grant logic; the FSM SHALL be inline.

Verification
REQ-029 The bench SHALL use a datapath model with mem[i]=2*i, 32 entries, and SHALL cover these scenarios:
- Reset, then req=01 with A0=20 -> rsp_valid=01, rsp_found=1, rsp_addr=10, rsp_err=0, latency odd and <=3+2*MAX_ITER.
- req=10 with A1=21 -> rsp_valid=10, rsp_found=0, rsp_err=0.
- req=11 after reset with A0=0, A1=62 -> requester 0 served first (addr 0), then requester 1 (addr 31); repeating req=11 serves 0 first again.
- Reset asserted during S_COMPUTE -> next cycle state is S_IDLE, all outputs 0, no rsp_valid pulse.
- Stub datapath with F and NF tied 0 -> rsp_err=1 after exactly 7 compute cycles, with rsp_valid pulsed once.
- req[0] dropped during S_GETMEM -> search completes and rsp_valid[0] still pulses once.
